// File: rtl/mod_add_sub.sv
// Two-stage modular add/subtract with valid/ready handshaking on both sides.
// S1 registers the raw sum/difference, S2 applies one conditional correction by Q.
module mod_add_sub #(
    parameter int               WIDTH = 64,
    parameter logic [WIDTH-1:0] Q     = WIDTH'(64'd1152921504606830593)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    logic             s1_valid;
    logic             s1_op;
    logic [WIDTH:0]   s1_raw;
    logic [WIDTH:0]   raw_next;
    logic [WIDTH-1:0] sub_q;
    logic [WIDTH-1:0] corr;
    logic             in_xfer;
    logic             s2_load;

    // in_ready is forced low while reset is held, not just after the next edge
    assign in_ready = !rst && (!s1_valid || !out_valid || out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign s2_load  = s1_valid && (!out_valid || out_ready);

    assign raw_next = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    assign sub_q    = s1_raw[WIDTH-1:0] - Q;

    // Single correction only: bit WIDTH is the carry for add, the borrow for sub
    always_comb begin
        corr = s1_raw[WIDTH-1:0];
        if (!s1_op) begin
            if (s1_raw >= {1'b0, Q}) corr = sub_q;
        end else if (s1_raw[WIDTH]) begin
            corr = s1_raw[WIDTH-1:0] + Q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= 1'b0;
            s1_raw   <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            s1_op    <= op;
            s1_raw   <= raw_next;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            result    <= corr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mod_add_sub.sv
// Directed vectors, handshake corner sequences and a scoreboarded random run
// for mod_add_sub at the default WIDTH/Q.
module tb_mod_add_sub;

    localparam int          W = 64;
    localparam logic [63:0] Q = 64'd1152921504606830593;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;

    mod_add_sub #(.WIDTH(W), .Q(Q)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic o, input logic [63:0] x, input logic [63:0] y);
        if (o) return (x >= y) ? x - y : (Q - y) + x;
        return (x + y) % Q;
    endfunction

    // Scoreboard monitor, sampled on the falling edge
    bit          mon_en = 1'b0;
    int          nacc = 0;
    logic [63:0] expq[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (in_valid && in_ready) begin
                expq.push_back(model(op, a, b));
                nacc++;
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) chk("rand_spurious", 64'd1, 64'd0);
                else chk("rand_result", result, expq.pop_front());
            end
        end
    end

    typedef struct {
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vec[10];
    int   acc;
    int   nout;

    initial begin
        vec[0] = '{1'b0, 64'd1152921504606830592, 64'd1, 64'd0};
        vec[1] = '{1'b0, 64'd5, 64'd128, 64'd133};
        vec[2] = '{1'b1, 64'd0, 64'd1, 64'd1152921504606830592};
        vec[3] = '{1'b1, 64'd200, 64'd72, 64'd128};
        vec[4] = '{1'b0, 64'd1152921504606830592, 64'd1152921504606830592, 64'd1152921504606830591};
        vec[5] = '{1'b1, 64'd1152921504606830592, 64'd1152921504606830592, 64'd0};
        vec[6] = '{1'b1, 64'd3, 64'd1152921504606830592, 64'd4};
        vec[7] = '{1'b0, 64'd0, 64'd0, 64'd0};
        // out-of-range operands: single-correction value only
        vec[8] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd17293822569102721022};
        vec[9] = '{1'b1, 64'd1152921504606830596, 64'd1, 64'd1152921504606830595};

        // Reset state while rst is held
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        #21 rst = 1'b0;
        #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Directed vectors, one at a time, latency 2
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            in_valid = 1'b1; op = vec[i].op; a = vec[i].a; b = vec[i].b;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("vec_latency_early", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
            chk("vec_valid", 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_result", i), result, vec[i].exp);
        end
        @(posedge clk); #1;
        chk("vec_drained", 64'(out_valid), 64'd0);

        // Back-to-back throughput
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                chk("b2b_in_ready", 64'(in_ready), 64'd1);
                in_valid = 1'b1; op = 1'b0; a = 64'(i + 1); b = 64'd10;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= 1 && i <= 4) begin
                chk("b2b_valid", 64'(out_valid), 64'd1);
                chk("b2b_result", result, 64'(10 + i));
            end else begin
                chk("b2b_idle", 64'(out_valid), 64'd0);
            end
        end

        // Backpressure: only two operations fit
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; op = 1'b0; a = 64'(20 + i); b = 64'd1;
            #1 if (in_ready) acc++;
            @(posedge clk); #1;
            if (i >= 1) chk("bp_hold_result", result, 64'd21);
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        #1 chk("bp_in_ready_same_cycle", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        chk("bp_second_result", result, 64'd22);
        @(posedge clk); #1;
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Reset mid-flight with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1; op = 1'b0; a = 64'd1; b = 64'd1;
        @(posedge clk); #1;
        a = 64'd2; b = 64'd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_full_in_ready", 64'(in_ready), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", result, 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #2 rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; op = 1'b0; a = 64'd7; b = 64'd8;
        nout = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) begin
                nout++;
                chk("mid_new_result", result, 64'd15);
            end
        end
        chk("mid_result_count", 64'(nout), 64'd1);

        // Random regression against the reference model
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 60000 && nacc < 10000; cyc++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            op = 1'($urandom_range(1));
            a = {$urandom, $urandom} % Q;
            b = {$urandom, $urandom} % Q;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("rand_accepted", 64'(nacc >= 10000), 64'd1);
        chk("rand_queue_empty", 64'(expq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
